// File: rtl/row_scheduler.sv
// Row scheduler: paces a row driver and a pixel generator through scan rows,
// ping-ponging a two-bank line buffer so the generator always fills the bank the driver is not reading.
module row_scheduler #(
  parameter int ROWS        = 32,
  parameter int HOLD_CYCLES = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       drv_start,
  input  logic       drv_idle,
  output logic       gen_start,
  input  logic       gen_idle,
  output logic [4:0] drv_y,
  output logic [9:0] drv_frame,
  output logic       drv_bank,
  output logic [4:0] gen_y,
  output logic [9:0] gen_frame,
  output logic       gen_bank,
  output logic       frame_tick,
  output logic       busy
);

  localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_PRIME_WAIT, S_ISSUE, S_WAIT, S_ADVANCE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [9:0]  frame_q, frame_d;
  logic        bank_q, bank_d;
  logic [15:0] timer_q, timer_d;
  logic [4:0]  drv_y_q, drv_y_d, gen_y_q, gen_y_d;
  logic [9:0]  drv_frame_q, drv_frame_d, gen_frame_q, gen_frame_d;
  logic        drv_bank_q, drv_bank_d, gen_bank_q, gen_bank_d;
  logic        load_issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      frame_q     <= '0;
      bank_q      <= 1'b0;
      timer_q     <= '0;
      drv_y_q     <= '0;
      drv_frame_q <= '0;
      drv_bank_q  <= 1'b0;
      gen_y_q     <= '0;
      gen_frame_q <= '0;
      gen_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      frame_q     <= frame_d;
      bank_q      <= bank_d;
      timer_q     <= timer_d;
      drv_y_q     <= drv_y_d;
      drv_frame_q <= drv_frame_d;
      drv_bank_q  <= drv_bank_d;
      gen_y_q     <= gen_y_d;
      gen_frame_q <= gen_frame_d;
      gen_bank_q  <= gen_bank_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    frame_d     = frame_q;
    bank_d      = bank_q;
    timer_d     = timer_q;
    drv_y_d     = drv_y_q;
    drv_frame_d = drv_frame_q;
    drv_bank_d  = drv_bank_q;
    gen_y_d     = gen_y_q;
    gen_frame_d = gen_frame_q;
    gen_bank_d  = gen_bank_q;
    drv_start   = 1'b0;
    gen_start   = 1'b0;
    frame_tick  = 1'b0;
    load_issue  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_PRIME;
          row_d       = '0;
          frame_d     = '0;
          bank_d      = 1'b0;
          drv_y_d     = '0;
          drv_frame_d = '0;
          drv_bank_d  = 1'b0;
          gen_y_d     = '0;
          gen_frame_d = '0;
          gen_bank_d  = 1'b0;
        end
      end
      S_PRIME: begin
        if (gen_idle) begin
          gen_start = 1'b1;
          state_d   = S_PRIME_WAIT;
        end
      end
      S_PRIME_WAIT: begin
        if (gen_idle) begin
          state_d    = S_ISSUE;
          load_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        if (drv_idle && gen_idle) begin
          drv_start = 1'b1;
          gen_start = 1'b1;
          timer_d   = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
        if (drv_idle && gen_idle && (timer_q >= HOLD_LAST)) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        row_d  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
        bank_d = ~bank_q;
        if (row_q == ROW_LAST) begin
          frame_d    = frame_q + 10'd1;
          frame_tick = 1'b1;
        end
        if (enable) begin
          state_d    = S_ISSUE;
          load_issue = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Slot addresses are captured on entry to ISSUE so they are already steady when the pulses fire.
    if (load_issue) begin
      drv_y_d     = row_d;
      drv_frame_d = frame_d;
      drv_bank_d  = bank_d;
      gen_y_d     = (row_d == ROW_LAST) ? 5'd0 : row_d + 5'd1;
      gen_frame_d = (row_d == ROW_LAST) ? frame_d + 10'd1 : frame_d;
      gen_bank_d  = ~bank_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign drv_y     = drv_y_q;
  assign drv_frame = drv_frame_q;
  assign drv_bank  = drv_bank_q;
  assign gen_y     = gen_y_q;
  assign gen_frame = gen_frame_q;
  assign gen_bank  = gen_bank_q;

endmodule

// File: tb/tb_row_scheduler.sv
// Bench for row_scheduler: behavioural driver/generator peers plus a scoreboard of expected start events.
module tb_row_scheduler;
  localparam int ROWS = 32;
  localparam int HOLD = 256;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       drv_start, gen_start, drv_idle, gen_idle;
  logic       drv_bank, gen_bank, frame_tick, busy;
  logic [4:0] drv_y, gen_y;
  logic [9:0] drv_frame, gen_frame;

  always #5 clock = ~clock;

  row_scheduler #(.ROWS(ROWS), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .drv_start(drv_start), .drv_idle(drv_idle),
    .gen_start(gen_start), .gen_idle(gen_idle),
    .drv_y(drv_y), .drv_frame(drv_frame), .drv_bank(drv_bank),
    .gen_y(gen_y), .gen_frame(gen_frame), .gen_bank(gen_bank),
    .frame_tick(frame_tick), .busy(busy)
  );

  // Peer models: busy for N cycles starting the cycle after their start pulse.
  int drv_n = 80;
  int gen_n = 64;
  int drv_cnt, gen_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) drv_cnt <= 0;
    else if (drv_start) drv_cnt <= drv_n;
    else if (drv_cnt > 0) drv_cnt <= drv_cnt - 1;
  end
  always @(posedge clock or posedge reset) begin
    if (reset) gen_cnt <= 0;
    else if (gen_start) gen_cnt <= gen_n;
    else if (gen_cnt > 0) gen_cnt <= gen_cnt - 1;
  end
  assign drv_idle = (drv_cnt == 0);
  assign gen_idle = (gen_cnt == 0);

  typedef struct {
    bit         is_drv;
    logic [4:0] dy;
    logic [9:0] df;
    logic       db;
    logic [4:0] gy;
    logic [9:0] gf;
    logic       gb;
    int         gap;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_pulse_cyc = 0;
  int  pulse_count = 0;
  int  tick_count = 0;
  bit  prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic ev_t prime_ev();
    ev_t e;
    e.is_drv = 1'b0;
    e.dy = '0; e.df = '0; e.db = 1'b0;
    e.gy = '0; e.gf = '0; e.gb = 1'b0;
    e.gap = -1;
    return e;
  endfunction

  // Slot k of a run started from row 0, frame 0, bank 0.
  function automatic ev_t slot_ev(input int k, input int gap);
    ev_t e;
    int r, f, b;
    r = k % ROWS;
    f = (k / ROWS) % 1024;
    b = k % 2;
    e.is_drv = 1'b1;
    e.dy = 5'(r);
    e.df = 10'(f);
    e.db = b[0];
    e.gy = 5'((r + 1) % ROWS);
    e.gf = (r == ROWS - 1) ? 10'((f + 1) % 1024) : 10'(f);
    e.gb = ~b[0];
    e.gap = gap;
    return e;
  endfunction

  // Cycles between consecutive drive issues given current peer busy lengths.
  function automatic int issue_gap();
    int m;
    m = ((drv_n > gen_n) ? drv_n : gen_n) + 1;
    if (m < HOLD) m = HOLD;
    return m + 2;
  endfunction

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset && (drv_start || gen_start)) begin
      ev_t e;
      pulse_count++;
      check("start_back_to_back", 32'(prev_pulse), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_start", {30'd0, drv_start, gen_start}, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn cyc=%0d drv_start=%0b drv_y=%0d drv_frame=%0d drv_bank=%0b gen_y=%0d gen_frame=%0d gen_bank=%0b",
                 cyc, drv_start, drv_y, drv_frame, drv_bank, gen_y, gen_frame, gen_bank);
        check("drv_start", 32'(drv_start), 32'(e.is_drv));
        check("gen_start", 32'(gen_start), 1);
        check("gen_y", 32'(gen_y), 32'(e.gy));
        check("gen_frame", 32'(gen_frame), 32'(e.gf));
        check("gen_bank", 32'(gen_bank), 32'(e.gb));
        if (e.is_drv) begin
          check("drv_y", 32'(drv_y), 32'(e.dy));
          check("drv_frame", 32'(drv_frame), 32'(e.df));
          check("drv_bank", 32'(drv_bank), 32'(e.db));
          check("drv_idle_at_issue", 32'(drv_idle), 1);
        end
        if (e.gap >= 0) check("start_gap", cyc - last_pulse_cyc, e.gap);
      end
      last_pulse_cyc = cyc;
    end
    if (!reset && frame_tick) tick_count++;
    prev_pulse = !reset && (drv_start || gen_start);
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_drv_start"}, 32'(drv_start), 0);
    check({pfx, "_gen_start"}, 32'(gen_start), 0);
    check({pfx, "_frame_tick"}, 32'(frame_tick), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_drv_y"}, 32'(drv_y), 0);
    check({pfx, "_gen_y"}, 32'(gen_y), 0);
    check({pfx, "_drv_frame"}, 32'(drv_frame), 0);
    check({pfx, "_gen_frame"}, 32'(gen_frame), 0);
    check({pfx, "_drv_bank"}, 32'(drv_bank), 0);
    check({pfx, "_gen_bank"}, 32'(gen_bank), 0);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_not_busy(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("busy_low", 32'(busy), 0);
  endtask

  initial begin
    int saved;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Startup and 33 slots through the frame wrap.
    exp_q.push_back(prime_ev());
    exp_q.push_back(slot_ev(0, gen_n + 2));
    for (int k = 1; k < 33; k++) exp_q.push_back(slot_ev(k, issue_gap()));
    enable = 1'b1;
    wait_empty(12000);
    check("frame_tick_count", tick_count, 1);

    // Drop enable inside the slot: it must finish on its normal schedule, then stay quiet.
    enable = 1'b0;
    wait_not_busy(2000);
    check("disable_to_idle", cyc - last_pulse_cyc, issue_gap());
    saved = pulse_count;
    repeat (600) @(negedge clock);
    check("no_pulse_after_disable", pulse_count, saved);
    check("idle_busy", 32'(busy), 0);

    // Re-enable with a slow driver: restart at row 0 and stretch the slot.
    drv_n = 300;
    exp_q.push_back(prime_ev());
    exp_q.push_back(slot_ev(0, gen_n + 2));
    for (int k = 1; k < 3; k++) exp_q.push_back(slot_ev(k, issue_gap()));
    enable = 1'b1;
    wait_empty(3000);

    // Asynchronous reset in the middle of a slot.
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check_all_zero("midslot_reset");
    @(negedge clock);
    reset = 1'b0;
    drv_n = 80;
    exp_q.push_back(prime_ev());
    exp_q.push_back(slot_ev(0, gen_n + 2));
    exp_q.push_back(slot_ev(1, issue_gap()));
    enable = 1'b1;
    wait_empty(2000);
    enable = 1'b0;
    wait_not_busy(2000);
    check("final_tick_count", tick_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
